// File: rtl/output_buffer_reader_pkg.sv
// rtl/output_buffer_reader_pkg.sv - shared accelerator types for the output buffer reader
package output_buffer_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } obr_state_e;

endpackage

// File: rtl/fifo_2entry.sv
// rtl/fifo_2entry.sv - two-entry first-word-fall-through FIFO with occupancy count
module fifo_2entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign count   = cnt_q;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/output_buffer_1x1.sv
// rtl/output_buffer_1x1.sv - pixel buffer with one write port and a registered read port
module output_buffer_1x1 #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_CHANNELS = 3,
  parameter int IN_WIDTH     = 5,
  parameter int IN_HEIGHT    = 5,
  localparam int NPIX          = IN_WIDTH * IN_HEIGHT,
  localparam int RD_ADDR_WIDTH = $clog2(NPIX),
  localparam int RD_DATA_WIDTH = DATA_WIDTH * OUT_CHANNELS
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [RD_ADDR_WIDTH-1:0] wr_addr,
  input  logic [RD_DATA_WIDTH-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_DATA_WIDTH-1:0] rd_data
);

  logic [RD_DATA_WIDTH-1:0] mem [NPIX];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/output_buffer_reader.sv
// rtl/output_buffer_reader.sv - streams every buffered pixel once per start with credit-based reads
module output_buffer_reader
  import output_buffer_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_CHANNELS = 3,
  parameter int IN_WIDTH     = 5,
  parameter int IN_HEIGHT    = 5,
  localparam int NPIX          = IN_WIDTH * IN_HEIGHT,
  localparam int RD_ADDR_WIDTH = $clog2(NPIX),
  localparam int RD_DATA_WIDTH = DATA_WIDTH * OUT_CHANNELS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     buf_rd_en,
  output logic [RD_ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [RD_DATA_WIDTH-1:0] buf_rd_data,
  output logic [RD_DATA_WIDTH-1:0] o_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_last
);

  localparam logic [RD_ADDR_WIDTH-1:0] LAST_ADDR = RD_ADDR_WIDTH'(NPIX - 1);

  obr_state_e               state_q;
  obr_state_e               state_d;
  logic [RD_ADDR_WIDTH-1:0] addr_q;
  logic                     inflight_q;
  logic                     inflight_last_q;
  logic                     done_q;
  logic                     rd_en;
  logic                     pop;
  logic                     last_addr;
  logic                     issue_ok;
  logic [2:0]               committed;

  logic [RD_DATA_WIDTH:0]   fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [1:0]               fifo_count;
  logic                     head_last;
  logic                     fifo_push;

  assign pop       = o_valid && o_ready;
  assign last_addr = (addr_q == LAST_ADDR);

  // Entries already held plus the read still in flight, minus what leaves this cycle.
  assign committed = {1'b0, fifo_count} + {2'b0, inflight_q};
  assign issue_ok  = committed < (3'd2 + {2'b0, pop});

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue_ok) begin
          rd_en = 1'b1;
          if (last_addr) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && o_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && last_addr;
      done_q          <= (state_q == DRAIN) && pop && o_last;
      if (state_q == IDLE && start) begin
        addr_q <= '0;
      end else if (rd_en && !last_addr) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // The last-pixel tag travels with its data so o_last always matches the head.
  assign fifo_push = inflight_q && (!fifo_full || pop);

  fifo_2entry #(
    .WIDTH (RD_DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({inflight_last_q, buf_rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_last, o_data} = fifo_head;
  assign o_valid     = !fifo_empty;
  assign o_last      = head_last && !fifo_empty;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign buf_rd_en   = rd_en;
  assign buf_rd_addr = addr_q;

endmodule

// File: doc/output_buffer_reader.md
OUTPUT_BUFFER_READER -- requirements
Module: output_buffer_reader

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, bits per channel.
- OUT_CHANNELS, default 3, channels per pixel.
- IN_WIDTH, default 5, pixels per row.
- IN_HEIGHT, default 5, rows.
REQ-002 Derived constants SHALL be:
- NPIX = IN_WIDTH*IN_HEIGHT.
- RD_ADDR_WIDTH = $clog2(NPIX).
- RD_DATA_WIDTH = DATA_WIDTH*OUT_CHANNELS.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start request.
- busy  out  1  high from accepted start until last beat handshaken.
- done  out  1  one-cycle pulse, frame complete.
- buf_rd_en  out  1  read strobe to the 1x1 output buffer.
- buf_rd_addr  out  RD_ADDR_WIDTH  pixel index to the buffer.
- buf_rd_data  in  RD_DATA_WIDTH  buffer data, valid one cycle after buf_rd_en; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- o_data  out  RD_DATA_WIDTH  pixel vector, same channel packing.
- o_valid  out  1  o_data valid.
- o_ready  in  1  downstream accepts.
- o_last  out  1  marks pixel NPIX-1.

Function
REQ-004 The block SHALL stream pixels 0..NPIX-1 once per accepted start, in ascending order, one beat per pixel.
REQ-005 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN on start.
- RUN->DRAIN in the cycle the read for pixel NPIX-1 issues.
- DRAIN->IDLE on the handshake of the last beat.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 Read data SHALL be captured into a 2-entry FIFO; o_valid SHALL equal FIFO non-empty; o_data SHALL be the FIFO head.
REQ-008 A read SHALL issue in RUN when occupancy + inflight - pop < 2, where:
- inflight = buf_rd_en of the previous cycle.
- pop = o_valid && o_ready.
REQ-009 The FIFO SHALL never overflow, and no pixel SHALL be dropped or duplicated.
REQ-010 buf_rd_addr SHALL increment by 1 per issued read, from 0 to NPIX-1, with no wrap within a frame.
REQ-011 Timing from start sampled at edge E0, with o_ready high:
- buf_rd_en with address 0 during the cycle after E0.
- o_valid high after E2.
- One beat per cycle thereafter.
REQ-012 While o_valid && !o_ready, o_data and o_last SHALL hold stable.
REQ-013 o_last SHALL be high exactly on the pixel NPIX-1 beat.
REQ-014 done SHALL pulse for one cycle, registered, in the cycle after the last handshake.
- busy SHALL be low in that cycle.
- A start in that cycle SHALL be accepted, giving back-to-back frames.
REQ-015 buf_rd_en SHALL be low in IDLE and DRAIN.

Reset
REQ-016 rst_n low SHALL asynchronously force the following, whether or not a frame is in progress:
- state IDLE.
- busy, done, buf_rd_en, o_valid, o_last = 0.
- buf_rd_addr = 0.
- FIFO empty, inflight cleared.
REQ-017 o_data SHALL reset to 0.
REQ-018 Data returned from a read in flight at reset SHALL be discarded.
REQ-019 After reset release, the next start SHALL restart at pixel 0.

Structure
REQ-020 The FSM state enum typedef SHALL live in the shared accelerator package.
REQ-021 The 2-entry FIFO SHALL be a sub-module named fifo_2entry, parameterised by width, with push, pop, full, empty and count.
REQ-022 Address counter, credit logic and FSM SHALL live in output_buffer_reader.

Verification
REQ-023 The bench SHALL instantiate output_buffer_1x1 with default parameters and preload pixel p, channel c with p*10+c.
REQ-024 Scenarios:
- Full throughput: start, o_ready=1 -> first o_valid 2 cycles after start; 25 consecutive beats; beat 6 = 0x3E3D3C; o_last on beat 24 = 0xF2F1F0; done the cycle after; busy low with done.
- Alternating backpressure: o_ready 1,0,1,0 -> identical 25-beat sequence; o_data stable while stalled; FIFO occupancy never exceeds 2.
- Long stall: o_ready=0 for 10 cycles after start -> exactly 2 buf_rd_en pulses (addr 0,1), then none; on release, beats 0..24 in order.
- Ignored start: start pulses during RUN and DRAIN -> no effect; a single done; 25 beats total.
- Reset mid-frame: rst_n low after beat 10 -> all outputs 0 immediately; new start -> beats restart at pixel 0 = 0x020100.
- Back-to-back: start in the done cycle -> second frame identical; first beat 2 cycles later.
